grant_scheduler: RTL and testbench
==================================

GRANT_SCHEDULER -- requirements
Module: grant_scheduler

Interface
REQ-001 The block SHALL have parameter MAX_HOLD, default 8, giving the maximum number of consecutive grant cycles before forced rotation; legal range is 2..255.
REQ-002 The block SHALL have port clk, input, 1 bit: the single clock; all state updates on its rising edge.
REQ-003 The block SHALL have port rst, input, 1 bit: the reset, synchronous and active-high.
REQ-004 The block SHALL have port req, input, 4 bits: level request per requester 0..3.
REQ-005 The block SHALL have port gnt, output, 4 bits: one-hot grant, all-zero when no owner.
REQ-006 The block SHALL have port sel, output, 2 bits: binary index of the owner, driving the 2-to-4 decoder select.
REQ-007 The block SHALL have port sel_en, output, 1 bit: decoder enable, high exactly when gnt is non-zero.
REQ-008 The block SHALL have port busy, output, 1 bit: high in states GRANT and GAP.

Function
REQ-009 The block SHALL implement FSM states IDLE, GRANT, GAP; all outputs SHALL be registered.
REQ-010 In IDLE or GAP with req != 0, the block SHALL pick the first set req bit searching ptr, ptr+1, ... modulo 4, and enter GRANT at the next edge with gnt/sel/sel_en asserted; latency is 1 cycle from sampled req.
REQ-011 In IDLE or GAP with req == 0, the block SHALL go to (or stay in) IDLE with gnt=0, sel=0, sel_en=0.
REQ-012 On entering GRANT, hold_cnt SHALL load 1; each further GRANT cycle SHALL increment it, saturating at MAX_HOLD.
REQ-013 In GRANT, if req[sel]==0 at an edge, the block SHALL go to GAP; gnt, sel_en SHALL be 0 and sel SHALL hold its last value in GAP.
REQ-014 In GRANT, if hold_cnt==MAX_HOLD and any other req bit is set, the block SHALL go to GAP (preemption) even though req[sel] is still high.
REQ-015 In GRANT, if hold_cnt==MAX_HOLD and no other req bit is set, the block SHALL keep the grant, with hold_cnt saturated.
REQ-016 On every GRANT->GAP transition, ptr SHALL become (sel+1) mod 4 (2-bit wrap: 3 -> 0).
REQ-017 GAP SHALL last exactly one cycle; gnt SHALL never switch directly between two non-zero values.
REQ-018 Release and preemption in the same cycle SHALL be treated as release; ptr SHALL update identically.
REQ-019 Changes on req bits other than the owner's SHALL have no effect during GRANT except through REQ-014.
REQ-020 gnt SHALL always equal the one-hot decode of sel when sel_en=1, and SHALL be 4'b0000 when sel_en=0.

Reset
REQ-021 With rst=1 at a rising edge, the block SHALL go to IDLE with gnt=0000, sel=00, sel_en=0, busy=0, ptr=0, hold_cnt=0, regardless of current state.
REQ-022 Reset SHALL take priority over every other transition, including mid-grant; req SHALL be ignored during the reset cycle.
REQ-023 The first arbitration after reset SHALL favour requester 0.

Verification
REQ-024 Reset then req=1111 held: the bench SHALL see gnt=0001 for 8 cycles, 1 GAP cycle of 0000, then 0010, 0100, 1000, 0001 in turn, each 8 cycles.
REQ-025 Single requester req=0100 held for 20 cycles: the bench SHALL see gnt=0100, sel=10, sel_en=1 continuously from cycle 2, with no GAP.
REQ-026 Owner 3 drops req after 3 cycles while req=1011: the bench SHALL see 1 GAP cycle, then gnt=0001 (ptr wrapped to 0).
REQ-027 rst=1 asserted mid-grant with gnt=0010: the bench SHALL see gnt=0000, busy=0 at the next edge; with req=1110 after release, the next grant SHALL be 0010.
REQ-028 Release coinciding with hold_cnt=MAX_HOLD, owner 1, req=1001 after: the bench SHALL see one GAP cycle, then gnt=1000.
REQ-029 All scenarios: the bench SHALL check every cycle that gnt is one-hot or zero and sel_en==|gnt.

Source files
------------

// File: rtl/grant_scheduler.sv
// Four-way round-robin grant scheduler with a bounded hold time and a mandatory
// one-cycle gap between owners. Every output is registered.
module grant_scheduler #(
    parameter int unsigned MAX_HOLD = 8
) (
    input  logic       clk,
    input  logic       rst,
    input  logic [3:0] req,
    output logic [3:0] gnt,
    output logic [1:0] sel,
    output logic       sel_en,
    output logic       busy
);

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        GRANT = 2'd1,
        GAP   = 2'd2
    } state_t;

    localparam logic [7:0] HOLD_MAX = 8'(MAX_HOLD);

    function automatic logic [3:0] decode(input logic [1:0] idx);
        return 4'b0001 << idx;
    endfunction

    // First set request bit, searching upward from p with modulo-4 wrap.
    function automatic logic [1:0] pick(input logic [3:0] r, input logic [1:0] p);
        logic [1:0] k;
        logic       found;
        pick  = p;
        found = 1'b0;
        for (int i = 0; i < 4; i++) begin
            k = p + 2'(i);
            if (!found && r[k]) begin
                pick  = k;
                found = 1'b1;
            end
        end
    endfunction

    state_t     state_r, state_s;
    logic [1:0] sel_r, sel_s;
    logic       sel_en_r, sel_en_s;
    logic [3:0] gnt_r, gnt_s;
    logic       busy_r, busy_s;
    logic [1:0] ptr_r, ptr_s;
    logic [7:0] hold_cnt_r, hold_cnt_s;
    logic [3:0] others_s;

    // Next-state and next-output computation.
    always_comb begin
        state_s    = state_r;
        sel_s      = sel_r;
        sel_en_s   = 1'b0;
        ptr_s      = ptr_r;
        hold_cnt_s = hold_cnt_r;
        others_s   = req & ~decode(sel_r);
        case (state_r)
            IDLE, GAP: begin
                if (req != 4'b0000) begin
                    state_s    = GRANT;
                    sel_s      = pick(req, ptr_r);
                    sel_en_s   = 1'b1;
                    hold_cnt_s = 8'd1;
                end else begin
                    state_s = IDLE;
                    sel_s   = 2'b00;
                end
            end
            GRANT: begin
                // A release wins over preemption; both rotate the pointer identically.
                if (!req[sel_r] || ((hold_cnt_r == HOLD_MAX) && (others_s != 4'b0000))) begin
                    state_s = GAP;
                    ptr_s   = sel_r + 2'd1;
                end else begin
                    sel_en_s = 1'b1;
                    if (hold_cnt_r != HOLD_MAX) begin
                        hold_cnt_s = hold_cnt_r + 8'd1;
                    end else begin
                        hold_cnt_s = hold_cnt_r;
                    end
                end
            end
            default: begin
                state_s = IDLE;
                sel_s   = 2'b00;
            end
        endcase
        gnt_s  = sel_en_s ? decode(sel_s) : 4'b0000;
        busy_s = (state_s != IDLE);
    end

    // State and output registers with synchronous reset.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_r    <= IDLE;
            sel_r      <= 2'b00;
            sel_en_r   <= 1'b0;
            gnt_r      <= 4'b0000;
            busy_r     <= 1'b0;
            ptr_r      <= 2'b00;
            hold_cnt_r <= 8'd0;
        end else begin
            state_r    <= state_s;
            sel_r      <= sel_s;
            sel_en_r   <= sel_en_s;
            gnt_r      <= gnt_s;
            busy_r     <= busy_s;
            ptr_r      <= ptr_s;
            hold_cnt_r <= hold_cnt_s;
        end
    end

    assign gnt    = gnt_r;
    assign sel    = sel_r;
    assign sel_en = sel_en_r;
    assign busy   = busy_r;

endmodule

// File: tb/tb_grant_scheduler.sv
// Bench for grant_scheduler: directed scenarios plus random traffic, checked
// against an owner/pointer reference model through an expectation queue.
module tb_grant_scheduler;

    localparam int MAXH = 8;

    logic       clk;
    logic       rst;
    logic [3:0] req;
    logic [3:0] gnt;
    logic [1:0] sel;
    logic       sel_en;
    logic       busy;

    grant_scheduler #(.MAX_HOLD(MAXH)) dut (
        .clk   (clk),
        .rst   (rst),
        .req   (req),
        .gnt   (gnt),
        .sel   (sel),
        .sel_en(sel_en),
        .busy  (busy)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct packed {
        logic [3:0] gnt;
        logic [1:0] sel;
        logic       sel_en;
        logic       busy;
    } exp_t;

    exp_t exp_q[$];
    int   tests = 0;
    int   fails = 0;

    // Reference model: who owns the resource, whether we sit in the gap, and
    // where the next search starts.
    int m_owner   = -1;
    bit m_gap     = 1'b0;
    int m_ptr     = 0;
    int m_held    = 0;
    int m_lastsel = 0;

    task automatic model(input logic r, input logic [3:0] q);
        if (r) begin
            m_owner = -1; m_gap = 1'b0; m_ptr = 0; m_held = 0; m_lastsel = 0;
        end else if (m_owner >= 0) begin
            if (!q[m_owner] || (m_held >= MAXH && (int'(q) & ~(1 << m_owner)) != 0)) begin
                m_lastsel = m_owner;
                m_ptr     = (m_owner + 1) % 4;
                m_owner   = -1;
                m_gap     = 1'b1;
            end else begin
                m_held = (m_held + 1 > MAXH) ? MAXH : m_held + 1;
            end
        end else if (q != 4'b0000) begin
            for (int i = 0; i < 4; i++) begin
                if (m_owner < 0 && q[(m_ptr + i) % 4]) m_owner = (m_ptr + i) % 4;
            end
            m_held = 1;
            m_gap  = 1'b0;
        end else begin
            m_gap     = 1'b0;
            m_lastsel = 0;
        end
    endtask

    function automatic exp_t model_out();
        exp_t e;
        e.sel_en = (m_owner >= 0);
        e.gnt    = (m_owner >= 0) ? 4'(1 << m_owner) : 4'b0000;
        e.sel    = (m_owner >= 0) ? 2'(m_owner) : (m_gap ? 2'(m_lastsel) : 2'b00);
        e.busy   = (m_owner >= 0) || m_gap;
        return e;
    endfunction

    // Drive one cycle of stimulus, queue the expected post-edge outputs.
    task automatic step(input logic r, input logic [3:0] q);
        rst = r;
        req = q;
        model(r, q);
        exp_q.push_back(model_out());
        @(negedge clk);
    endtask

    task automatic expect_gnt(input string name, input logic [3:0] want);
        tests++;
        if (gnt !== want) begin
            fails++;
            $display("FAIL %s: gnt=%b expected %b at %0t", name, gnt, want, $time);
        end
    endtask

    // Monitor: pop an expectation after every rising edge and compare.
    initial begin
        exp_t e;
        forever begin
            @(posedge clk);
            #1;
            tests++;
            if ((gnt & (gnt - 4'd1)) != 4'b0000 || sel_en !== (|gnt)) begin
                fails++;
                $display("FAIL invariant: gnt=%b sel_en=%b at %0t", gnt, sel_en, $time);
            end
            if (exp_q.size() > 0) begin
                e = exp_q.pop_front();
                tests++;
                if ({gnt, sel, sel_en, busy} !== e) begin
                    fails++;
                    $display("FAIL scoreboard: gnt=%b sel=%b sel_en=%b busy=%b expected gnt=%b sel=%b sel_en=%b busy=%b at %0t",
                             gnt, sel, sel_en, busy, e.gnt, e.sel, e.sel_en, e.busy, $time);
                end
            end
        end
    end

    initial begin
        logic [3:0] rq;
        logic [3:0] seq[5];
        seq[0] = 4'b0001; seq[1] = 4'b0010; seq[2] = 4'b0100; seq[3] = 4'b1000; seq[4] = 4'b0001;
        rst = 1'b1;
        req = 4'b0000;

        // Full contention rotates every MAX_HOLD cycles with a single gap.
        step(1'b1, 4'b1111);
        expect_gnt("reset", 4'b0000);
        for (int k = 0; k < 5; k++) begin
            for (int c = 0; c < MAXH; c++) begin
                step(1'b0, 4'b1111);
                expect_gnt("rotate", seq[k]);
            end
            if (k < 4) begin
                step(1'b0, 4'b1111);
                expect_gnt("rotate_gap", 4'b0000);
            end
        end

        // Lone requester keeps the grant indefinitely.
        step(1'b1, 4'b0000);
        for (int c = 0; c < 20; c++) begin
            step(1'b0, 4'b0100);
            expect_gnt("single", 4'b0100);
        end

        // Owner 3 releases; pointer wraps to requester 0.
        step(1'b1, 4'b0000);
        step(1'b0, 4'b1000);
        expect_gnt("own3", 4'b1000);
        step(1'b0, 4'b1011);
        step(1'b0, 4'b1011);
        step(1'b0, 4'b0011);
        expect_gnt("own3_gap", 4'b0000);
        step(1'b0, 4'b0011);
        expect_gnt("wrap0", 4'b0001);

        // Reset in the middle of a grant.
        step(1'b1, 4'b0000);
        step(1'b0, 4'b0010);
        expect_gnt("own1", 4'b0010);
        step(1'b1, 4'b0010);
        expect_gnt("mid_reset", 4'b0000);
        step(1'b0, 4'b1110);
        expect_gnt("after_reset", 4'b0010);

        // Release coinciding with saturated hold count.
        step(1'b1, 4'b0000);
        for (int c = 0; c < MAXH; c++) step(1'b0, 4'b0010);
        expect_gnt("sat_hold", 4'b0010);
        step(1'b0, 4'b1001);
        expect_gnt("sat_gap", 4'b0000);
        step(1'b0, 4'b1001);
        expect_gnt("sat_next", 4'b1000);

        // Random traffic with sticky requests and occasional resets.
        rq = 4'b0000;
        for (int c = 0; c < 3000; c++) begin
            if ($urandom_range(0, 3) == 0) rq = 4'($urandom_range(0, 15));
            step(($urandom_range(0, 63) == 0), rq);
        end

        @(posedge clk);
        #2;
        tests++;
        if (exp_q.size() != 0) begin
            fails++;
            $display("FAIL drain: %0d expectations left, expected 0", exp_q.size());
        end
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
